// File: rtl/sys_arr_ctrl.sv
// Job sequencer for a weight-stationary systolic array: weight load, skewed
// activation streaming, per-column result-valid tracking and done signalling.
module sys_arr_ctrl #(
  parameter int unsigned ROWS  = 2,
  parameter int unsigned COLS  = 2,
  parameter int unsigned VEC_W = 8,
  localparam int unsigned AW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  skip_wload,
  input  logic [VEC_W-1:0]      num_vec,
  output logic                  busy,
  output logic                  done,
  output logic                  w_rd_en,
  output logic [AW-1:0]         w_rd_addr,
  input  logic [8*COLS-1:0]     w_rd_data,
  output logic [8*COLS-1:0]     arr_win,
  output logic [COLS-1:0]       arr_wwrite,
  output logic                  a_rd_en,
  output logic [VEC_W-1:0]      a_rd_addr,
  input  logic [8*ROWS-1:0]     a_rd_data,
  output logic [8*ROWS-1:0]     arr_datain,
  output logic [ROWS-1:0]       arr_active,
  output logic [COLS-1:0]       res_valid,
  output logic [VEC_W*COLS-1:0] res_idx
);

  // Read strobe to final bottom-right result: 1 (buffer) + ROWS + COLS hops.
  localparam int unsigned PL = ROWS + COLS + 1;
  localparam logic [PL-1:0] LAST_ONLY = {1'b1, {(PL-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [VEC_W-1:0] n_q, n_d;
  logic [VEC_W-1:0] vcnt_q, vcnt_d;
  logic [AW-1:0]    wcnt_q, wcnt_d;
  logic             busy_d, done_d, w_rd_en_d, a_rd_en_d;
  logic [PL-1:0]    vpipe_q;
  logic [VEC_W-1:0] ipipe_q [PL];

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    vcnt_d  = vcnt_q;
    wcnt_d  = wcnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !busy) begin
          n_d     = num_vec;
          vcnt_d  = '0;
          wcnt_d  = AW'(ROWS - 1);
          state_d = skip_wload ? STREAM : LOAD_W;
        end
      end
      LOAD_W: begin
        if (wcnt_q == '0) state_d = STREAM;
        else              wcnt_d  = wcnt_q - AW'(1);
      end
      STREAM: begin
        if (n_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (vcnt_q == n_q - VEC_W'(1)) begin
          state_d = DRAIN;
        end else begin
          vcnt_d = vcnt_q + VEC_W'(1);
        end
      end
      DRAIN: begin
        // Only the final result remains in flight: it is on the outputs now.
        if (vpipe_q == LAST_ONLY) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    w_rd_en_d = (state_d == LOAD_W);
    a_rd_en_d = (state_d == STREAM) && (n_d != '0);
    busy_d    = (state_d != IDLE) || done_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      n_q        <= '0;
      vcnt_q     <= '0;
      wcnt_q     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      w_rd_en    <= 1'b0;
      w_rd_addr  <= '0;
      arr_wwrite <= '0;
      a_rd_en    <= 1'b0;
      a_rd_addr  <= '0;
      vpipe_q    <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      vcnt_q     <= vcnt_d;
      wcnt_q     <= wcnt_d;
      busy       <= busy_d;
      done       <= done_d;
      w_rd_en    <= w_rd_en_d;
      w_rd_addr  <= w_rd_en_d ? wcnt_d : '0;
      arr_wwrite <= {COLS{w_rd_en}};
      a_rd_en    <= a_rd_en_d;
      a_rd_addr  <= a_rd_en_d ? vcnt_d : '0;
      vpipe_q    <= {vpipe_q[PL-2:0], a_rd_en};
    end
  end

  // Vector index travels alongside the valid pipeline.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(PL); i++) ipipe_q[i] <= '0;
    end else begin
      ipipe_q[0] <= a_rd_addr;
      for (int i = 1; i < int'(PL); i++) ipipe_q[i] <= ipipe_q[i-1];
    end
  end

  assign arr_win   = arr_wwrite[0] ? w_rd_data : '0;
  assign res_valid = vpipe_q[PL-1 -: COLS];

  for (genvar c = 0; c < int'(COLS); c++) begin : g_res
    assign res_idx[VEC_W*c +: VEC_W] = ipipe_q[ROWS+1+c];
  end

  // Row r skew: r+1 registers fed by buffer data and the returned-read flag.
  for (genvar r = 0; r < int'(ROWS); r++) begin : g_row
    logic [7:0] d_q   [r+1];
    logic       act_q [r+1];

    always_ff @(posedge clock) begin
      if (reset) begin
        for (int i = 0; i <= r; i++) begin
          d_q[i]   <= '0;
          act_q[i] <= 1'b0;
        end
      end else begin
        act_q[0] <= vpipe_q[0];
        d_q[0]   <= vpipe_q[0] ? a_rd_data[8*r +: 8] : 8'd0;
        for (int i = 1; i <= r; i++) begin
          act_q[i] <= act_q[i-1];
          d_q[i]   <= d_q[i-1];
        end
      end
    end

    assign arr_datain[8*r +: 8] = d_q[r];
    assign arr_active[r]        = act_q[r];
  end

endmodule
